// File: rtl/key_evt_if.sv
// Valid/ready event port between the key scheduler (master) and its consumer (slave).
interface key_evt_if #(
  parameter int CODE_W = 2
);
  logic              evt_valid;
  logic              evt_ready;
  logic [CODE_W-1:0] evt_code;

  modport master (output evt_valid, output evt_code, input evt_ready);
  modport slave  (input evt_valid, input evt_code, output evt_ready);
endinterface

// File: rtl/key_evt_sched.sv
// Round-robin scheduler serialising per-key press pulses onto one valid/ready event port.
// Optional macro KEY_EVT_CNT_EN adds the evt_count accepted-event counter port.
module key_evt_sched #(
  parameter int NUM_KEYS = 4,
  parameter int CODE_W   = 2,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] key_pulse,
  key_evt_if.master           evt,
  input  logic                ovf_clr,
`ifdef KEY_EVT_CNT_EN
  output logic                ovf_flag,
  output logic [CNT_W-1:0]    evt_count
`else
  output logic                ovf_flag
`endif
);

  typedef enum logic {ST_IDLE = 1'b0, ST_PRESENT = 1'b1} state_t;

  state_t              state_r, state_s;
  logic [NUM_KEYS-1:0] pending_r, pending_s, load_mask_s;
  logic [CODE_W-1:0]   ptr_r, ptr_next_s, sel_idx_s, code_r;
  logic [CODE_W:0]     idx_s;
  logic                valid_r, sel_found_s, accept_s, load_s, ovf_set_s;

  assign evt.evt_valid = valid_r;
  assign evt.evt_code  = code_r;

  // Rotating search for the first pending key starting at ptr.
  always_comb begin
    sel_found_s = 1'b0;
    sel_idx_s   = '0;
    idx_s       = '0;
    for (int k = 0; k < NUM_KEYS; k++) begin
      idx_s = {1'b0, ptr_r} + (CODE_W+1)'(k);
      if (idx_s >= (CODE_W+1)'(NUM_KEYS)) begin
        idx_s = idx_s - (CODE_W+1)'(NUM_KEYS);
      end else begin
        idx_s = idx_s;
      end
      if (!sel_found_s && pending_r[idx_s[CODE_W-1:0]]) begin
        sel_found_s = 1'b1;
        sel_idx_s   = idx_s[CODE_W-1:0];
      end else begin
        sel_found_s = sel_found_s;
      end
    end
    if (sel_idx_s == CODE_W'(NUM_KEYS - 1)) begin
      ptr_next_s = '0;
    end else begin
      ptr_next_s = sel_idx_s + CODE_W'(1);
    end
  end

  // FSM next state, load decision and pending/overflow bookkeeping.
  always_comb begin
    state_s  = state_r;
    accept_s = valid_r & evt.evt_ready;
    load_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (sel_found_s) begin
          load_s  = 1'b1;
          state_s = ST_PRESENT;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_PRESENT: begin
        if (accept_s && sel_found_s) begin
          load_s = 1'b1;
        end else if (accept_s) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_PRESENT;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
    if (load_s) begin
      load_mask_s = NUM_KEYS'(1) << sel_idx_s;
    end else begin
      load_mask_s = '0;
    end
    // A pulse on a key being loaded this edge refills its slot rather than overflowing.
    pending_s = (pending_r & ~load_mask_s) | key_pulse;
    ovf_set_s = |(key_pulse & pending_r & ~load_mask_s);
  end

  // State, pending set, output register and sticky overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      pending_r <= '0;
      ptr_r     <= '0;
      code_r    <= '0;
      valid_r   <= 1'b0;
      ovf_flag  <= 1'b0;
    end else begin
      state_r   <= state_s;
      pending_r <= pending_s;
      valid_r   <= (state_s == ST_PRESENT);
      if (load_s) begin
        code_r <= sel_idx_s;
        ptr_r  <= ptr_next_s;
      end
      if (ovf_set_s) begin
        ovf_flag <= 1'b1;
      end else if (ovf_clr) begin
        ovf_flag <= 1'b0;
      end
    end
  end

`ifdef KEY_EVT_CNT_EN
  // Accepted-event counter, wraps naturally at 2^CNT_W.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      evt_count <= '0;
    end else if (accept_s) begin
      evt_count <= evt_count + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_key_evt_sched.sv
// Randomized and directed bench for key_evt_sched against a behavioural queue model.
module tb_key_evt_sched;
  localparam int NUM_KEYS = 4;
  localparam int CODE_W   = 2;
`ifdef KEY_EVT_CNT_EN
  localparam int CNT_W    = 4;
`else
  localparam int CNT_W    = 16;
`endif

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [NUM_KEYS-1:0] key_pulse = '0;
  logic                ovf_clr = 1'b0;
  logic                ovf_flag;
`ifdef KEY_EVT_CNT_EN
  logic [CNT_W-1:0]    evt_count;
`endif

  key_evt_if #(.CODE_W(CODE_W)) evt_bus ();

  key_evt_sched #(.NUM_KEYS(NUM_KEYS), .CODE_W(CODE_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .key_pulse (key_pulse),
    .evt       (evt_bus),
    .ovf_clr   (ovf_clr),
`ifdef KEY_EVT_CNT_EN
    .ovf_flag  (ovf_flag),
    .evt_count (evt_count)
`else
    .ovf_flag  (ovf_flag)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: pending slots, rotation pointer, output register.
  bit mpend [NUM_KEYS];
  int mptr, mcode, mcnt, acc_total;
  bit mvalid, movf;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_KEYS; i++) mpend[i] = 1'b0;
    mptr = 0; mcode = 0; mcnt = 0; mvalid = 1'b0; movf = 1'b0;
  endtask

  task automatic model_edge(input logic [NUM_KEYS-1:0] p, input bit rdy, input bit clr);
    bit acc, ld, ovs, lo;
    int sel;
    acc = mvalid && rdy;
    sel = -1;
    for (int k = 0; k < NUM_KEYS; k++)
      if (sel < 0 && mpend[(mptr + k) % NUM_KEYS]) sel = (mptr + k) % NUM_KEYS;
    ld  = (sel >= 0) && (!mvalid || acc);
    ovs = 1'b0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      lo = ld && (sel == i);
      if (p[i] && mpend[i] && !lo) ovs = 1'b1;
      mpend[i] = (mpend[i] && !lo) || p[i];
    end
    if (ld) begin
      mcode = sel; mptr = (sel + 1) % NUM_KEYS; mvalid = 1'b1;
    end else if (acc) begin
      mvalid = 1'b0;
    end
    if (ovs) movf = 1'b1;
    else if (clr) movf = 1'b0;
    if (acc) begin
      mcnt = (mcnt + 1) % (1 << CNT_W);
      acc_total++;
    end
  endtask

  task automatic compare_model(input string tag);
    check_val({tag, ".valid"}, 32'(evt_bus.evt_valid), 32'(mvalid));
    check_val({tag, ".code"},  32'(evt_bus.evt_code),  32'(mcode));
    check_val({tag, ".ovf"},   32'(ovf_flag),          32'(movf));
`ifdef KEY_EVT_CNT_EN
    check_val({tag, ".cnt"},   32'(evt_count),         32'(mcnt));
`endif
  endtask

  // Drive one cycle of inputs, clock it, then compare against the model.
  task automatic step(input logic [NUM_KEYS-1:0] p, input bit rdy, input bit clr, input string tag);
    key_pulse = p; evt_bus.evt_ready = rdy; ovf_clr = clr;
    model_edge(p, rdy, clr);
    @(posedge clk);
    #1;
    compare_model(tag);
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    key_pulse = '0; ovf_clr = 1'b0; evt_bus.evt_ready = 1'b0;
    #2;
    model_reset();
    check_val("rst.valid", 32'(evt_bus.evt_valid), 32'd0);
    check_val("rst.code",  32'(evt_bus.evt_code),  32'd0);
    check_val("rst.ovf",   32'(ovf_flag),          32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int accepts;
    bit seen3;
    evt_bus.evt_ready = 1'b0;
    acc_total = 0;
    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    // Reset while presenting with keys 1 and 2 pending.
    step(4'b0001, 1'b0, 1'b0, "t1a");
    step(4'b0110, 1'b0, 1'b0, "t1b");
    check_val("t1.valid_before", 32'(evt_bus.evt_valid), 32'd1);
    do_reset();
    for (int c = 0; c < 5; c++) begin
      step(4'b0000, 1'b1, 1'b0, "t1c");
      check_val("t1.no_evt", 32'(evt_bus.evt_valid), 32'd0);
    end

    // Single pulse on key 2, then pointer moves to 3.
    step(4'b0100, 1'b1, 1'b0, "t2a");
    check_val("t2.lat0", 32'(evt_bus.evt_valid), 32'd0);
    step(4'b0000, 1'b1, 1'b0, "t2b");
    check_val("t2.valid", 32'(evt_bus.evt_valid), 32'd1);
    check_val("t2.code",  32'(evt_bus.evt_code),  32'd2);
    step(4'b1001, 1'b1, 1'b0, "t2c");
    check_val("t2.one_cycle", 32'(evt_bus.evt_valid), 32'd0);
    step(4'b0000, 1'b1, 1'b0, "t2d");
    check_val("t2.ptr3", 32'(evt_bus.evt_code), 32'd3);
    step(4'b0000, 1'b1, 1'b0, "t2e");
    check_val("t2.wrap0", 32'(evt_bus.evt_code), 32'd0);

    // Three simultaneous pulses drain back-to-back.
    do_reset();
    step(4'b1011, 1'b1, 1'b0, "t3a");
    step(4'b0000, 1'b1, 1'b0, "t3b");
    check_val("t3.code0", 32'(evt_bus.evt_code), 32'd0);
    step(4'b0000, 1'b1, 1'b0, "t3c");
    check_val("t3.code1", 32'(evt_bus.evt_code), 32'd1);
    check_val("t3.valid1", 32'(evt_bus.evt_valid), 32'd1);
    step(4'b0000, 1'b1, 1'b0, "t3d");
    check_val("t3.code3", 32'(evt_bus.evt_code), 32'd3);
    check_val("t3.valid3", 32'(evt_bus.evt_valid), 32'd1);
    step(4'b0000, 1'b1, 1'b0, "t3e");
    check_val("t3.done", 32'(evt_bus.evt_valid), 32'd0);

    // Overflow: one slot queued behind the presented event, third pulse overflows.
    do_reset();
    step(4'b0010, 1'b0, 1'b0, "t4a");
    step(4'b0000, 1'b0, 1'b0, "t4b");
    for (int c = 0; c < 9; c++) step(4'b0000, 1'b0, 1'b0, "t4w");
    step(4'b0010, 1'b0, 1'b0, "t4c");
    check_val("t4.kept", 32'(ovf_flag), 32'd0);
    for (int c = 0; c < 3; c++) step(4'b0000, 1'b0, 1'b0, "t4w2");
    step(4'b0010, 1'b0, 1'b0, "t4d");
    check_val("t4.ovf", 32'(ovf_flag), 32'd1);
    step(4'b0000, 1'b0, 1'b1, "t4e");
    check_val("t4.clr", 32'(ovf_flag), 32'd0);
    step(4'b0010, 1'b0, 1'b1, "t4f");
    check_val("t4.set_wins", 32'(ovf_flag), 32'd1);

    // Fairness: key 0 hammered, key 3 pulsed once.
    do_reset();
    accepts = 0;
    seen3 = 1'b0;
    for (int c = 0; c < 40 && !seen3; c++) begin
      if (evt_bus.evt_valid) begin
        if (evt_bus.evt_code == 2'd3) seen3 = 1'b1;
        else accepts++;
      end
      if (!seen3) step((c == 0) ? 4'b1001 : 4'b0001, 1'b1, 1'b0, "t5");
    end
    check_val("t5.granted", 32'(seen3), 32'd1);
    check_val("t5.within", 32'(accepts <= NUM_KEYS), 32'd1);

`ifdef KEY_EVT_CNT_EN
    // Counter wrap after 17 accepts with a 4-bit counter.
    do_reset();
    acc_total = 0;
    for (int c = 0; c < 60 && acc_total < 17; c++) step(4'b1111, 1'b1, 1'b0, "t6");
    check_val("t6.wrap", 32'(evt_count), 32'd1);
`endif

    // Randomized traffic with stalls, overflow clears and bursts.
    do_reset();
    for (int c = 0; c < 600; c++) begin
      logic [NUM_KEYS-1:0] p;
      p = '0;
      for (int i = 0; i < NUM_KEYS; i++) p[i] = ($urandom_range(0, 5) == 0);
      step(p, ($urandom_range(0, 2) != 0), ($urandom_range(0, 9) == 0), "rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
